// File: rtl/sysbus_pkg.sv
// Sysbus types and line geometry shared by the response router and both cache refill paths.
package sysbus_pkg;

    typedef enum logic {
        DEST_IC = 1'b0,
        DEST_DC = 1'b1
    } dest_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } router_state_e;

    localparam int SYSBUS_BEATS_PER_LINE = 8;
    localparam int SYSBUS_SRC_BIT        = 12;

endpackage

// File: rtl/resp_fifo.sv
// Generic beat FIFO: entry vector in, head vector out, pointer-based full/empty.
// Latency: a push is visible at the head on the next cycle when the FIFO was empty.
// Backpressure: a push is dropped while full (even with a same-cycle pop); the caller must gate on full.
module resp_fifo #(
    parameter int WIDTH = 78,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bus_resp_router.sv
// Routes Sysbus response bursts to I-/D-cache beat FIFOs by tag bit; RESP_ROUTER_TAGCHK_EN adds a sticky mid-burst tag check.
// Latency: an accepted beat is presented on the cache port one cycle later when that FIFO was empty.
// Backpressure: bus_respack drops while the destination FIFO is full; the beat is held on the bus.
module bus_resp_router
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS_PER_LINE = SYSBUS_BEATS_PER_LINE,
    parameter int FIFO_DEPTH     = 4,
    parameter int SRC_BIT        = SYSBUS_SRC_BIT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic                      ic_resp_valid,
    output logic [BUS_DATA_WIDTH-1:0] ic_resp_data,
    output logic [BUS_TAG_WIDTH-1:0]  ic_resp_tag,
    output logic                      ic_resp_last,
    input  logic                      ic_resp_ready,
    output logic                      dc_resp_valid,
    output logic [BUS_DATA_WIDTH-1:0] dc_resp_data,
    output logic [BUS_TAG_WIDTH-1:0]  dc_resp_tag,
    output logic                      dc_resp_last,
    input  logic                      dc_resp_ready,
    output logic                      tag_err
);

    localparam int ENTRY_W = 1 + BUS_TAG_WIDTH + BUS_DATA_WIDTH;
    localparam int CNT_W   = $clog2(BEATS_PER_LINE);

    router_state_e      state;
    router_state_e      state_nxt;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   beat_cnt_nxt;
    dest_e              dest_q;
    dest_e              dest_nxt;
    dest_e              dest;
    logic               beat_vld;
    logic               beat_last;
    logic               ic_full;
    logic               dc_full;
    logic               ic_empty;
    logic               dc_empty;
    logic [ENTRY_W-1:0] push_dat;
    logic [ENTRY_W-1:0] ic_head;
    logic [ENTRY_W-1:0] dc_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            dest_q   <= DEST_IC;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            dest_q   <= dest_nxt;
        end
    end

    // Accept depends only on the bus and full flags, never on the cache readies.
    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        dest_nxt     = dest_q;
        dest         = (state == BURST) ? dest_q : dest_e'(bus_resptag[SRC_BIT]);
        bus_respack  = reset && bus_respcyc && !((dest == DEST_DC) ? dc_full : ic_full);
        beat_vld     = bus_respcyc && bus_respack;
        beat_last    = (state == BURST) && (beat_cnt == CNT_W'(BEATS_PER_LINE - 1));
        if (beat_vld) begin
            beat_cnt_nxt = beat_cnt + 1'b1;
            case (state)
                IDLE: begin
                    dest_nxt  = dest;
                    state_nxt = BURST;
                end
                BURST: begin
                    if (beat_last) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign push_dat = {beat_last, bus_resptag, bus_resp};

    resp_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_ic_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (beat_vld && (dest == DEST_IC)),
        .push_dat (push_dat),
        .full     (ic_full),
        .pop      (ic_resp_valid && ic_resp_ready),
        .empty    (ic_empty),
        .head_dat (ic_head)
    );

    resp_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_dc_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (beat_vld && (dest == DEST_DC)),
        .push_dat (push_dat),
        .full     (dc_full),
        .pop      (dc_resp_valid && dc_resp_ready),
        .empty    (dc_empty),
        .head_dat (dc_head)
    );

    assign ic_resp_valid = !ic_empty;
    assign dc_resp_valid = !dc_empty;
    assign {ic_resp_last, ic_resp_tag, ic_resp_data} = ic_head;
    assign {dc_resp_last, dc_resp_tag, dc_resp_data} = dc_head;

`ifdef RESP_ROUTER_TAGCHK_EN
    logic [BUS_TAG_WIDTH-1:0] first_tag;
    logic                     tag_err_q;

    // Routing ignores mismatches; this only flags them until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_tag <= '0;
            tag_err_q <= 1'b0;
        end else if (beat_vld) begin
            if (state == IDLE) begin
                first_tag <= bus_resptag;
            end else if (bus_resptag != first_tag) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    assign tag_err = tag_err_q;
`else
    assign tag_err = 1'b0;
`endif

endmodule
